// File: rtl/k_vector_stream.sv
// Streams K[0..K_LENGTH-1] from an external ROM to the round engine through a prefetch FIFO.
// First word on k_valid_o 2+ROM_LATENCY cycles after start_i; ROM reads are credit-limited so k_ready_i stalls never overflow the FIFO.
module k_vector_stream #(
    parameter int K_LENGTH    = 64,
    parameter int WORD_W      = 32,
    parameter int ROM_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable_i,
    input  logic                        start_i,
    output logic [$clog2(K_LENGTH)-1:0] k_addr_o,
    output logic                        k_read_o,
    input  logic [WORD_W-1:0]           k_data_i,
    input  logic                        k_ready_i,
    output logic                        k_valid_o,
    output logic [WORD_W-1:0]           k_value_o,
    output logic [$clog2(K_LENGTH)-1:0] k_round_o,
    output logic                        busy_o,
    output logic                        k_done_o
);
    localparam int AW = $clog2(K_LENGTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;
    localparam int SW = NW + 3;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                 state_q;
    logic [AW-1:0]          addr_q;
    logic                   rd_q;
    logic [CW-1:0]          pop_cnt_q;
    logic                   busy_q;
    logic                   done_q;
    logic [ROM_LATENCY-1:0] pipe_q;
    logic [ROM_LATENCY-1:0] pipe_d;
    logic [WORD_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q;
    logic [PW-1:0]          rd_ptr_q;
    logic [NW-1:0]          count_q;
    logic [NW-1:0]          count_d;
    logic [SW-1:0]          in_flight_d;
    logic                   clr;
    logic                   push;
    logic                   pop;
    logic                   last_issue;
    logic                   last_pop;
    logic                   credit_ok;

    assign clr        = reset | ~enable_i;
    assign push       = pipe_q[ROM_LATENCY-1];
    assign pop        = (count_q != '0) & k_ready_i;
    assign last_issue = rd_q & (addr_q == AW'(K_LENGTH - 1));
    assign last_pop   = pop & (pop_cnt_q == CW'(K_LENGTH - 1));
    assign pipe_d     = (pipe_q << 1) | ROM_LATENCY'(rd_q);
    assign count_d    = count_q + NW'(push) - NW'(pop);

    // Credit for the read registered now: next-cycle occupancy plus reads still in the ROM pipe.
    always_comb begin
        in_flight_d = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            in_flight_d = in_flight_d + SW'(pipe_d[i]);
        end
        credit_ok = (SW'(count_d) + in_flight_d) < SW'(FIFO_DEPTH);
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            pop_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (pop) begin
                pop_cnt_q <= pop_cnt_q + CW'(1);
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q   <= FETCH;
                        addr_q    <= '0;
                        rd_q      <= 1'b1;
                        pop_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                FETCH: begin
                    if (last_issue) begin
                        state_q <= DRAIN;
                        rd_q    <= 1'b0;
                    end else begin
                        if (rd_q) begin
                            addr_q <= addr_q + AW'(1);
                        end
                        rd_q <= credit_ok;
                    end
                end
                DRAIN: begin
                    if (last_pop) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clr) begin
            pipe_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pipe_q  <= pipe_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= k_data_i;
        end
    end

    assign k_addr_o  = addr_q;
    assign k_read_o  = rd_q;
    assign k_valid_o = (count_q != '0);
    assign k_value_o = k_valid_o ? mem_q[rd_ptr_q] : '0;
    assign k_round_o = pop_cnt_q[AW-1:0];
    assign busy_o    = busy_q;
    assign k_done_o  = done_q;
endmodule

// File: tb/tb_k_vector_stream.sv
// Instance a: SHA-256 defaults, ROM latency 1. Instance b: SHA-512 (80 x 64-bit), ROM latency 3.
// Scoreboard queues hold the expected K sequence per block; monitors compare every accepted word.
module tb_k_vector_stream;
    typedef struct packed {
        logic [6:0]  rnd;
        logic [63:0] val;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [63:0] k512 [80];
    bit mon_on = 1'b0;

    logic        a_reset, a_en, a_start, a_read, a_ready, a_valid, a_busy, a_done;
    logic [5:0]  a_addr, a_round;
    logic [31:0] a_data, a_value;
    logic        b_reset, b_en, b_start, b_read, b_ready, b_valid, b_busy, b_done;
    logic [6:0]  b_addr, b_round;
    logic [63:0] b_data, b_value;

    exp_t qa[$];
    exp_t qb[$];
    int   a_iss, a_pop, b_iss, b_pop;
    bit   a_act, b_act, a_done_exp, b_done_exp;
    bit   a_stall_prev, b_stall_prev;
    logic [31:0] a_hold;
    logic [63:0] b_hold, b_first_val, b_last_val;
    logic [6:0]  b_last_rnd;
    logic        b_s0_v, b_s1_v;
    logic [6:0]  b_s0_a, b_s1_a;

    k_vector_stream u_a (
        .clock(clock), .reset(a_reset), .enable_i(a_en), .start_i(a_start),
        .k_addr_o(a_addr), .k_read_o(a_read), .k_data_i(a_data), .k_ready_i(a_ready),
        .k_valid_o(a_valid), .k_value_o(a_value), .k_round_o(a_round),
        .busy_o(a_busy), .k_done_o(a_done)
    );

    k_vector_stream #(.K_LENGTH(80), .WORD_W(64), .ROM_LATENCY(3), .FIFO_DEPTH(4)) u_b (
        .clock(clock), .reset(b_reset), .enable_i(b_en), .start_i(b_start),
        .k_addr_o(b_addr), .k_read_o(b_read), .k_data_i(b_data), .k_ready_i(b_ready),
        .k_valid_o(b_valid), .k_value_o(b_value), .k_round_o(b_round),
        .busy_o(b_busy), .k_done_o(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ROM models; they are never reset, so reads issued before an abort still return data.
    always @(posedge clock) begin
        a_data <= a_read ? k512[a_addr][63:32] : 32'hDEAD_BEEF;
        b_s0_v <= b_read;
        b_s0_a <= b_addr;
        b_s1_v <= b_s0_v;
        b_s1_a <= b_s0_a;
        b_data <= b_s1_v ? k512[b_s1_a] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    always @(negedge clock) begin
        bit   exp_rd;
        exp_t e;
        if (mon_on) begin
            if (a_reset || !a_en) begin
                a_stall_prev = 1'b0;
            end else begin
                exp_rd = a_act && (a_iss < 64) && ((a_iss - a_pop) < 4);
                chk("a_k_read_credit", a_read, exp_rd);
                if (a_read) begin
                    chk("a_k_addr", a_addr, a_iss);
                    a_iss++;
                end
                chk("a_k_done", a_done, a_done_exp);
                if (a_stall_prev && a_valid) chk("a_value_hold", a_value, a_hold);
                if (a_valid && a_ready) begin
                    if (qa.size() == 0) begin
                        chk("a_pop_unexpected", a_valid, 0);
                    end else begin
                        e = qa.pop_front();
                        chk("a_k_value", a_value, e.val);
                        chk("a_k_round", a_round, e.rnd);
                    end
                    a_pop++;
                    if (a_pop == 64) a_done_exp = 1'b1;
                end
                a_stall_prev = a_valid && !a_ready;
                a_hold = a_value;
            end
        end
    end

    always @(negedge clock) begin
        bit   exp_rd;
        exp_t e;
        if (mon_on) begin
            if (b_reset || !b_en) begin
                b_stall_prev = 1'b0;
            end else begin
                exp_rd = b_act && (b_iss < 80) && ((b_iss - b_pop) < 4);
                chk("b_k_read_credit", b_read, exp_rd);
                if (b_read) begin
                    chk("b_k_addr", b_addr, b_iss);
                    b_iss++;
                end
                chk("b_k_done", b_done, b_done_exp);
                if (b_stall_prev && b_valid) chk("b_value_hold", b_value, b_hold);
                if (b_valid && b_ready) begin
                    if (qb.size() == 0) begin
                        chk("b_pop_unexpected", b_valid, 0);
                    end else begin
                        e = qb.pop_front();
                        chk("b_k_value", b_value, e.val);
                        chk("b_k_round", b_round, e.rnd);
                    end
                    if (b_pop == 0) b_first_val = b_value;
                    b_last_val = b_value;
                    b_last_rnd = b_round;
                    b_pop++;
                    if (b_pop == 80) b_done_exp = 1'b1;
                end
                b_stall_prev = b_valid && !b_ready;
                b_hold = b_value;
            end
        end
    end

    task automatic zero_chk_a();
        chk("a_zero_valid", a_valid, 0);  chk("a_zero_read", a_read, 0);
        chk("a_zero_busy", a_busy, 0);    chk("a_zero_done", a_done, 0);
        chk("a_zero_value", a_value, 0);  chk("a_zero_round", a_round, 0);
        chk("a_zero_addr", a_addr, 0);
    endtask

    task automatic zero_chk_b();
        chk("b_zero_valid", b_valid, 0);  chk("b_zero_read", b_read, 0);
        chk("b_zero_busy", b_busy, 0);    chk("b_zero_done", b_done, 0);
        chk("b_zero_value", b_value, 0);  chk("b_zero_round", b_round, 0);
        chk("b_zero_addr", b_addr, 0);
    endtask

    task automatic start_a();
        exp_t e;
        @(posedge clock); #1;
        a_start = 1'b1;
        a_act = 1'b0;
        @(posedge clock); #1;
        a_start = 1'b0;
        qa.delete();
        for (int i = 0; i < 64; i++) begin
            e.rnd = 7'(i);
            e.val = {32'h0, k512[i][63:32]};
            qa.push_back(e);
        end
        a_iss = 0; a_pop = 0; a_done_exp = 1'b0; a_act = 1'b1;
    endtask

    task automatic start_b();
        exp_t e;
        @(posedge clock); #1;
        b_start = 1'b1;
        b_act = 1'b0;
        @(posedge clock); #1;
        b_start = 1'b0;
        qb.delete();
        for (int i = 0; i < 80; i++) begin
            e.rnd = 7'(i);
            e.val = k512[i];
            qb.push_back(e);
        end
        b_iss = 0; b_pop = 0; b_done_exp = 1'b0; b_act = 1'b1;
    endtask

    task automatic abort_a(input bit use_enable);
        @(posedge clock); #1;
        if (use_enable) a_en = 1'b0; else a_reset = 1'b1;
        a_act = 1'b0; qa.delete(); a_iss = 0; a_pop = 0; a_done_exp = 1'b0;
        @(posedge clock); #1;
        a_en = 1'b1; a_reset = 1'b0;
        @(negedge clock);
        zero_chk_a();
    endtask

    task automatic abort_b(input bit use_enable);
        @(posedge clock); #1;
        if (use_enable) b_en = 1'b0; else b_reset = 1'b1;
        b_act = 1'b0; qb.delete(); b_iss = 0; b_pop = 0; b_done_exp = 1'b0;
        @(posedge clock); #1;
        b_en = 1'b1; b_reset = 1'b0;
        @(negedge clock);
        zero_chk_b();
    endtask

    task automatic wait_iss_a(input int lim);
        for (int n = 0; n < lim && a_iss < 64; n++) begin @(posedge clock); #1; end
        chk("a_reached_drain", a_iss, 64);
    endtask

    task automatic wait_done_a(input int lim);
        for (int n = 0; n < lim && !a_done_exp; n++) begin @(posedge clock); #1; end
        chk("a_done_level", a_done, 1);
        chk("a_pop_count", a_pop, 64);
        chk("a_read_count", a_iss, 64);
        chk("a_queue_empty", qa.size(), 0);
        chk("a_busy_after_done", a_busy, 0);
    endtask

    task automatic wait_done_b(input int lim);
        for (int n = 0; n < lim && !b_done_exp; n++) begin @(posedge clock); #1; end
        chk("b_done_level", b_done, 1);
        chk("b_pop_count", b_pop, 80);
        chk("b_read_count", b_iss, 80);
        chk("b_queue_empty", qb.size(), 0);
        chk("b_busy_after_done", b_busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL tb_watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        k512 = '{
            64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
            64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
            64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
            64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
            64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
            64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
            64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
            64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
            64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
            64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
            64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
            64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
            64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
            64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
            64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
            64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
            64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
            64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
            64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
            64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
        };
        a_reset = 1'b1; a_en = 1'b1; a_start = 1'b0; a_ready = 1'b1;
        b_reset = 1'b1; b_en = 1'b1; b_start = 1'b0; b_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clock);
        zero_chk_a();
        zero_chk_b();
        @(posedge clock); #1;
        mon_on = 1'b1;

        // Full SHA-256 block with k_ready held high.
        start_a();
        wait_done_a(300);

        // start during FETCH and DRAIN is ignored; start in DONE restarts at K[0].
        start_a();
        repeat (10) @(posedge clock);
        #1;
        a_start = 1'b1;
        @(posedge clock); #1;
        a_start = 1'b0;
        wait_iss_a(300);
        a_ready = 1'b0;
        a_start = 1'b1;
        @(posedge clock); #1;
        a_start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("a_drain_busy", a_busy, 1);
        a_ready = 1'b1;
        wait_done_a(100);
        start_a();
        wait_done_a(300);

        // Engine stalled from the start: only FIFO_DEPTH reads, then enable dropped mid-DRAIN.
        a_ready = 1'b0;
        start_a();
        repeat (20) @(posedge clock);
        #1;
        chk("a_stall_read_count", a_iss, 4);
        chk("a_stall_valid", a_valid, 1);
        chk("a_stall_head", a_value, 32'h428a2f98);
        a_ready = 1'b1;
        wait_iss_a(300);
        a_ready = 1'b0;
        @(posedge clock); #1;
        chk("a_drain_before_abort", a_busy, 1);
        abort_a(1'b1);
        a_ready = 1'b1;
        start_a();
        wait_done_a(300);

        // SHA-512 table, ROM latency 3, random back-pressure.
        start_b();
        for (int n = 0; n < 3000 && !b_done_exp; n++) begin
            b_ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        b_ready = 1'b1;
        wait_done_b(20);
        chk("b_last_value", b_last_val, 64'h6c44198c4a475817);
        chk("b_last_round", b_last_rnd, 79);

        // Reset with reads outstanding: late ROM data must be dropped.
        start_b();
        for (int n = 0; n < 300 && b_pop < 10; n++) begin @(posedge clock); #1; end
        chk("b_reached_pop10", b_pop >= 10, 1);
        abort_b(1'b0);
        repeat (10) @(posedge clock);
        #1;
        chk("b_idle_after_reset", b_valid, 0);
        start_b();
        wait_done_b(400);
        chk("b_first_after_reset", b_first_val, 64'h428a2f98d728ae22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
